sram_blwl_prog_ctrl: RTL and testbench

SRAM_BLWL_PROG_CTRL -- requirements
Module: sram_blwl_prog_ctrl

---
 rtl/sram_blwl_prog_ctrl_if.sv | 38 +++
 rtl/sram_blwl_prog_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_sram_blwl_prog_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_blwl_prog_ctrl_if.sv
// Request/array bundle for the bit-line/word-line programming controller.
// read and rd_dout exist only when SRAM_PROG_VERIFY_EN is defined.
interface sram_blwl_prog_ctrl_if #(
  parameter int NUM_CELLS = 16,
  parameter int ADDR_W    = 4
);
  logic                 prog_valid;
  logic                 prog_ready;
  logic [ADDR_W-1:0]    prog_addr;
  logic                 prog_data;
  logic                 bl;
  logic [NUM_CELLS-1:0] wl;
  logic                 busy;
  logic                 prog_done;
  logic                 prog_err;
`ifdef SRAM_PROG_VERIFY_EN
  logic                 read;
  logic                 rd_dout;

  modport master (
    output prog_valid, prog_addr, prog_data, rd_dout,
    input  prog_ready, bl, wl, busy, prog_done, prog_err, read
  );
  modport slave (
    input  prog_valid, prog_addr, prog_data, rd_dout,
    output prog_ready, bl, wl, busy, prog_done, prog_err, read
  );
`else
  modport master (
    output prog_valid, prog_addr, prog_data,
    input  prog_ready, bl, wl, busy, prog_done, prog_err
  );
  modport slave (
    input  prog_valid, prog_addr, prog_data,
    output prog_ready, bl, wl, busy, prog_done, prog_err
  );
`endif
endinterface

// File: rtl/sram_blwl_prog_ctrl.sv
// Sequences one configuration-cell write: bl setup, wl pulse, hold, done.
// Define SRAM_PROG_VERIFY_EN to add a read-back verify with bounded retries.
module sram_blwl_prog_ctrl #(
  parameter int NUM_CELLS = 16,
  parameter int ADDR_W    = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_blwl_prog_ctrl_if.slave  bus
);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || MAX_RETRY < 0) begin : g_bad_timing
    $error("sram_blwl_prog_ctrl: SETUP_CYC/PULSE_CYC must be >= 1, MAX_RETRY >= 0");
  end
  if ((2 ** ADDR_W) < NUM_CELLS) begin : g_bad_addr_w
    $error("sram_blwl_prog_ctrl: ADDR_W too narrow for NUM_CELLS");
  end

  localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [ADDR_W:0]   CELLS     = (ADDR_W + 1)'(NUM_CELLS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
`ifdef SRAM_PROG_VERIFY_EN
    VERIFY,
`endif
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 data_q, data_d;
  logic                 addr_ok;

  logic                 bl_q, bl_d;
  logic [NUM_CELLS-1:0] wl_q, wl_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

`ifdef SRAM_PROG_VERIFY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 read_q, read_d;
  logic                 rd_match;

  assign rd_match = (bus.rd_dout == data_q);
`endif

  assign addr_ok = ({1'b0, addr_q} < CELLS);

  // State register plus registered outputs; every array-facing pin is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= 1'b0;
      bl_q    <= 1'b0;
      wl_q    <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SRAM_PROG_VERIFY_EN
      retry_q <= '0;
      read_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking here so every flop samples pre-edge values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bl_q    <= bl_d;
      wl_q    <= wl_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SRAM_PROG_VERIFY_EN
      retry_q <= retry_d;
      read_q  <= read_d;
`endif
    end
  end

  always_comb begin
    // NOTE: defaults first so no branch leaves a variable unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef SRAM_PROG_VERIFY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.prog_valid && ready_q) begin
          state_d = SETUP;
          cnt_d   = '0;
          addr_d  = bus.prog_addr;
          data_d  = bus.prog_data;
`ifdef SRAM_PROG_VERIFY_EN
          retry_d = '0;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
`ifdef SRAM_PROG_VERIFY_EN
        state_d = addr_ok ? VERIFY : DONE;
        cnt_d   = '0;
`else
        state_d = DONE;
`endif
      end
`ifdef SRAM_PROG_VERIFY_EN
      // Two read cycles; the cell output is trusted only on the second.
      VERIFY: begin
        if (cnt_q == '0) begin
          cnt_d = cnt_q + 1'b1;
        end else if (rd_match) begin
          state_d = DONE;
        end else if (retry_q < RETRY_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = SETUP;
          cnt_d   = '0;
        end else begin
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so the registered pins line up with state_q.
  always_comb begin
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
    bl_d    = (state_d != IDLE) ? data_d : 1'b0;
    wl_d    = '0;
    err_d   = 1'b0;
    if (state_d == PULSE && addr_ok) begin
      wl_d = NUM_CELLS'(1) << addr_q;
    end
`ifdef SRAM_PROG_VERIFY_EN
    read_d = (state_d == VERIFY);
    // Reaching DONE straight from VERIFY on a mismatch means retries ran out.
    if (done_d) begin
      err_d = !addr_ok || (state_q == VERIFY && !rd_match);
    end
`else
    if (done_d) begin
      err_d = !addr_ok;
    end
`endif
  end

  assign bus.prog_ready = ready_q;
  assign bus.bl         = bl_q;
  assign bus.wl         = wl_q;
  assign bus.busy       = busy_q;
  assign bus.prog_done  = done_q;
  assign bus.prog_err   = err_q;
`ifdef SRAM_PROG_VERIFY_EN
  assign bus.read       = read_q;
`endif

endmodule

// File: tb/tb_sram_blwl_prog_ctrl.sv
// Directed bench for sram_blwl_prog_ctrl: table of single writes plus
// back-to-back, out-of-range and reset-mid-pulse sequences.
module tb_sram_blwl_prog_ctrl;

  localparam int NUM_CELLS = 16;
  localparam int ADDR_W    = 5;
  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 4;
  localparam int MAX_RETRY = 2;
  // Cycle 1 is the cycle opened by the accept edge; DONE lands in cycle 8.
  localparam int BASE_LAT  = 8;
`ifdef SRAM_PROG_VERIFY_EN
  localparam int VEXTRA    = 2;
`else
  localparam int VEXTRA    = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sram_blwl_prog_ctrl_if #(.NUM_CELLS(NUM_CELLS), .ADDR_W(ADDR_W)) bus ();

  sram_blwl_prog_ctrl #(
    .NUM_CELLS (NUM_CELLS),
    .ADDR_W    (ADDR_W),
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef SRAM_PROG_VERIFY_EN
  // Cell model: reads back what is on the bit line unless forced stuck-at-0.
  logic stuck0 = 1'b0;
  assign bus.rd_dout = stuck0 ? 1'b0 : bus.bl;
`endif

  typedef struct {
    logic [ADDR_W-1:0]    addr;
    logic                 data;
    logic [NUM_CELLS-1:0] exp_wl;
    int                   exp_pulses;
    logic                 exp_err;
  } vec_t;

  typedef struct {
    int   lat;
    int   pulses;
    int   wl_cycles;
    int   first_wl;
    logic err;
    logic ready_before;
    logic wl_bad;
    logic bl_bad;
    logic busy_bad;
  } meas_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one write and records what the array pins did until prog_done.
  task automatic run_write(input logic [ADDR_W-1:0] a, input logic d,
                           input logic [NUM_CELLS-1:0] exp_wl, output meas_t m);
    logic [NUM_CELLS-1:0] prev_wl;
    m = '{default: 0};
    @(negedge clk);
    m.ready_before  = bus.prog_ready;
    bus.prog_valid  = 1'b1;
    bus.prog_addr   = a;
    bus.prog_data   = d;
    @(posedge clk);
    @(negedge clk);
    bus.prog_valid  = 1'b0;
    prev_wl = '0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (bus.wl != '0 && bus.wl != exp_wl) m.wl_bad = 1'b1;
      if (bus.wl != '0) begin
        m.wl_cycles++;
        if (m.first_wl == 0) m.first_wl = cyc;
        if (prev_wl == '0) m.pulses++;
      end
      if (bus.bl !== d) m.bl_bad = 1'b1;
      if (bus.busy !== 1'b1 || bus.prog_ready !== 1'b0) m.busy_bad = 1'b1;
      prev_wl = bus.wl;
      if (bus.prog_done === 1'b1) begin
        m.lat = cyc;
        m.err = bus.prog_err;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[5];
    meas_t m;
    logic [NUM_CELLS-1:0] wl_first, wl_second;
    logic multi, bl1_bad, bl2_bad, gap_idle;
    int   d1, d2, exp_lat;

    vecs[0] = '{addr: 5'd5,  data: 1'b1, exp_wl: 16'h0020, exp_pulses: 1, exp_err: 1'b0};
    vecs[1] = '{addr: 5'd0,  data: 1'b1, exp_wl: 16'h0001, exp_pulses: 1, exp_err: 1'b0};
    vecs[2] = '{addr: 5'd15, data: 1'b0, exp_wl: 16'h8000, exp_pulses: 1, exp_err: 1'b0};
    vecs[3] = '{addr: 5'd20, data: 1'b1, exp_wl: 16'h0000, exp_pulses: 0, exp_err: 1'b1};
    vecs[4] = '{addr: 5'd9,  data: 1'b0, exp_wl: 16'h0200, exp_pulses: 1, exp_err: 1'b0};

    bus.prog_valid = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_data  = 1'b0;
    rst = 1'b1;

    #12;
    check("rst_wl",    bus.wl,         16'h0000);
    check("rst_bl",    bus.bl,         1'b0);
    check("rst_busy",  bus.busy,       1'b0);
    check("rst_done",  bus.prog_done,  1'b0);
    check("rst_err",   bus.prog_err,   1'b0);
    check("rst_ready", bus.prog_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.prog_ready, 1'b1);

    for (int i = 0; i < 5; i++) begin
      run_write(vecs[i].addr, vecs[i].data, vecs[i].exp_wl, m);
      exp_lat = (vecs[i].exp_pulses != 0) ? BASE_LAT + VEXTRA : BASE_LAT;
      check($sformatf("v%0d_ready", i),    m.ready_before, 1'b1);
      check($sformatf("v%0d_latency", i),  m.lat,          exp_lat);
      check($sformatf("v%0d_pulses", i),   m.pulses,       vecs[i].exp_pulses);
      check($sformatf("v%0d_wl_width", i), m.wl_cycles,    vecs[i].exp_pulses * PULSE_CYC);
      check($sformatf("v%0d_wl_rise", i),  m.first_wl,     (vecs[i].exp_pulses != 0) ? SETUP_CYC + 1 : 0);
      check($sformatf("v%0d_err", i),      m.err,          vecs[i].exp_err);
      check($sformatf("v%0d_wl_bits", i),  m.wl_bad,       1'b0);
      check($sformatf("v%0d_bl", i),       m.bl_bad,       1'b0);
      check($sformatf("v%0d_busy", i),     m.busy_bad,     1'b0);
      @(negedge clk);
      check($sformatf("v%0d_done_1cyc", i), bus.prog_done,  1'b0);
      check($sformatf("v%0d_idle_bl", i),   bus.bl,         1'b0);
      check($sformatf("v%0d_idle_busy", i), bus.busy,       1'b0);
      check($sformatf("v%0d_idle_rdy", i),  bus.prog_ready, 1'b1);
    end

    // Back-to-back: valid held, second request presented while the first is busy.
    @(negedge clk);
    bus.prog_valid = 1'b1;
    bus.prog_addr  = 5'd0;
    bus.prog_data  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.prog_addr  = 5'd15;
    bus.prog_data  = 1'b0;
    wl_first = '0; wl_second = '0;
    multi = 1'b0; bl1_bad = 1'b0; bl2_bad = 1'b0; gap_idle = 1'b0;
    d1 = 0; d2 = 0;
    for (int cyc = 1; cyc <= 80 && d2 == 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (!$onehot0(bus.wl)) multi = 1'b1;
      if (d1 == 0) begin
        wl_first |= bus.wl;
        if (bus.bl !== 1'b1) bl1_bad = 1'b1;
      end else begin
        wl_second |= bus.wl;
        if (cyc > d1 + 1 && bus.bl !== 1'b0) bl2_bad = 1'b1;
      end
      if (cyc == d1 + 1 && d1 != 0)
        gap_idle = bus.prog_ready && !bus.busy && !bus.bl;
      if (bus.prog_done === 1'b1) begin
        if (d1 == 0) d1 = cyc;
        else         d2 = cyc;
      end
    end
    bus.prog_valid = 1'b0;
    check("b2b_done1",     d1,        BASE_LAT + VEXTRA);
    check("b2b_done2",     d2,        2 * (BASE_LAT + VEXTRA) + 1);
    check("b2b_idle_gap",  gap_idle,  1'b1);
    check("b2b_wl_first",  wl_first,  16'h0001);
    check("b2b_wl_second", wl_second, 16'h8000);
    check("b2b_onehot",    multi,     1'b0);
    check("b2b_bl_first",  bl1_bad,   1'b0);
    check("b2b_bl_second", bl2_bad,   1'b0);

    // Reset on the second PULSE cycle of addr=3 must drop wl without a clock edge.
    @(negedge clk);
    bus.prog_valid = 1'b1;
    bus.prog_addr  = 5'd3;
    bus.prog_data  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.prog_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_pulse_wl", bus.wl, 16'h0008);
    #1 rst = 1'b1;
    #1;
    check("async_wl",    bus.wl,         16'h0000);
    check("async_bl",    bus.bl,         1'b0);
    check("async_busy",  bus.busy,       1'b0);
    check("async_done",  bus.prog_done,  1'b0);
    check("async_err",   bus.prog_err,   1'b0);
    check("async_ready", bus.prog_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rerst_ready", bus.prog_ready, 1'b1);
    run_write(5'd3, 1'b1, 16'h0008, m);
    check("post_rst_latency", m.lat,      BASE_LAT + VEXTRA);
    check("post_rst_pulses",  m.pulses,   1);
    check("post_rst_wl_bits", m.wl_bad,   1'b0);
    check("post_rst_err",     m.err,      1'b0);

`ifdef SRAM_PROG_VERIFY_EN
    // Stuck-at-0 cell: initial write plus MAX_RETRY retries, then error.
    stuck0 = 1'b1;
    run_write(5'd7, 1'b1, 16'h0080, m);
    stuck0 = 1'b0;
    check("stuck_pulses",   m.pulses,    3);
    check("stuck_wl_width", m.wl_cycles, 3 * PULSE_CYC);
    check("stuck_latency",  m.lat,       28);
    check("stuck_err",      m.err,       1'b1);
    check("stuck_bl",       m.bl_bad,    1'b0);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
